// File: rtl/nes_read_sequencer_pkg.sv
`default_nettype none
// nes_pkg: shared state encoding, button bit positions and a small state helper
// for the NES controller read sequencer.
package nes_pkg;

   localparam int NES_BITS = 8;

   localparam int BTN_A      = 0;
   localparam int BTN_B      = 1;
   localparam int BTN_SELECT = 2;
   localparam int BTN_START  = 3;
   localparam int BTN_UP     = 4;
   localparam int BTN_DOWN   = 5;
   localparam int BTN_LEFT   = 6;
   localparam int BTN_RIGHT  = 7;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LATCH = 3'd1,
      READ  = 3'd2,
      PULSE = 3'd3,
      DONE  = 3'd4
   } nes_state_t;

   // The protocol tick only runs while the controller pins are being driven.
   function automatic logic is_active(input nes_state_t s);
      return (s == LATCH) || (s == READ) || (s == PULSE);
   endfunction

endpackage
`default_nettype wire

// File: rtl/nes_read_sequencer_if.sv
`default_nettype none
// nes_read_sequencer_if: system-side request/result signals plus controller pins.
// Optional `pressed` byte exists only when NES_PRESS_EDGE_EN is defined.
interface nes_read_sequencer_if;
   import nes_pkg::*;

   logic                start;
   logic                nes_data;
   logic                nes_latch;
   logic                nes_pulse;
   logic [NES_BITS-1:0] buttons;
   logic                valid;
   logic                busy;
`ifdef NES_PRESS_EDGE_EN
   logic [NES_BITS-1:0] pressed;
`endif

   // master: system logic and controller together; slave: the sequencer.
   modport master (
      output start,
      output nes_data,
      input  nes_latch,
      input  nes_pulse,
      input  buttons,
      input  valid,
      input  busy
`ifdef NES_PRESS_EDGE_EN
      , input pressed
`endif
   );

   modport slave (
      input  start,
      input  nes_data,
      output nes_latch,
      output nes_pulse,
      output buttons,
      output valid,
      output busy
`ifdef NES_PRESS_EDGE_EN
      , output pressed
`endif
   );

endinterface
`default_nettype wire

// File: rtl/nes_read_sequencer_tick.sv
`default_nettype none
// nes_tick_gen: one-cycle tick every CLK_DIV clocks while enabled; the
// divider restarts from zero whenever enable drops.
module nes_tick_gen #(
   parameter int CLK_DIV = 4
) (
   input  wire logic clk,
   input  wire logic reset_n,
   input  wire logic enable,
   output logic      tick
);

   localparam int            CW   = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

   logic [CW-1:0] count;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count <= '0;
      end else if (!enable) begin
         count <= '0;
      end else if (count == LAST) begin
         count <= '0;
      end else begin
         count <= count + 1'b1;
      end
   end

   assign tick = enable && (count == LAST);

endmodule
`default_nettype wire

// File: rtl/nes_read_sequencer.sv
`default_nettype none
// nes_read_sequencer: one NES controller read (latch, 8 shift pulses, serial
// capture) per request. Define NES_PRESS_EDGE_EN to add the `pressed` edge byte.
module nes_read_sequencer
   import nes_pkg::*;
#(
   parameter int CLK_DIV   = 4,
   parameter int AUTO_POLL = 0
) (
   input  wire logic            clk,
   input  wire logic            reset_n,
   nes_read_sequencer_if.slave  bus
);

   localparam logic [2:0] LAST_BIT = 3'(NES_BITS - 1);
   localparam logic       AUTO     = (AUTO_POLL != 0);

   nes_state_t          state;
   logic [2:0]          bit_cnt;
   logic                latch_half;
   logic [NES_BITS-1:0] shift;
   logic [NES_BITS-1:0] buttons_q;
   logic                latch_q;
   logic                pulse_q;
   logic                valid_q;
   logic                busy_q;
   logic                tick;
   logic                tick_en;
`ifdef NES_PRESS_EDGE_EN
   logic [NES_BITS-1:0] pressed_q;
`endif

   assign tick_en = is_active(state);

   nes_tick_gen #(
      .CLK_DIV (CLK_DIV)
   ) u_tick (
      .clk     (clk),
      .reset_n (reset_n),
      .enable  (tick_en),
      .tick    (tick)
   );

   // Pin/status flops are loaded alongside the state transition so they stay
   // glitch-free and line up exactly with the state they belong to.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         bit_cnt    <= 3'd0;
         latch_half <= 1'b0;
         shift      <= '0;
         buttons_q  <= '0;
         latch_q    <= 1'b0;
         pulse_q    <= 1'b0;
         valid_q    <= 1'b0;
         busy_q     <= 1'b0;
`ifdef NES_PRESS_EDGE_EN
         pressed_q  <= '0;
`endif
      end else begin
         valid_q   <= 1'b0;
`ifdef NES_PRESS_EDGE_EN
         pressed_q <= '0;
`endif
         case (state)
            IDLE: begin
               if (bus.start || AUTO) begin
                  state      <= LATCH;
                  latch_q    <= 1'b1;
                  busy_q     <= 1'b1;
                  latch_half <= 1'b0;
               end
            end
            LATCH: begin
               if (tick) begin
                  if (latch_half) begin
                     state   <= READ;
                     latch_q <= 1'b0;
                     bit_cnt <= 3'd0;
                  end else begin
                     latch_half <= 1'b1;
                  end
               end
            end
            READ: begin
               if (tick) begin
                  shift[bit_cnt] <= ~bus.nes_data;
                  state          <= PULSE;
                  pulse_q        <= 1'b1;
               end
            end
            PULSE: begin
               if (tick) begin
                  pulse_q <= 1'b0;
                  bit_cnt <= bit_cnt + 3'd1;
                  if (bit_cnt == LAST_BIT) begin
                     state     <= DONE;
                     buttons_q <= shift;
                     valid_q   <= 1'b1;
                     busy_q    <= 1'b0;
`ifdef NES_PRESS_EDGE_EN
                     pressed_q <= shift & ~buttons_q;
`endif
                  end else begin
                     state <= READ;
                  end
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state   <= IDLE;
               latch_q <= 1'b0;
               pulse_q <= 1'b0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.nes_latch = latch_q;
   assign bus.nes_pulse = pulse_q;
   assign bus.buttons   = buttons_q;
   assign bus.valid     = valid_q;
   assign bus.busy      = busy_q;
`ifdef NES_PRESS_EDGE_EN
   assign bus.pressed   = pressed_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_nes_read_sequencer.sv
`default_nettype none
// tb_nes_read_sequencer: scoreboard bench with a behavioural NES pad model,
// one start-driven instance and one AUTO_POLL instance.
module tb_nes_read_sequencer;
   import nes_pkg::*;

   typedef struct {
      logic [7:0] btn;
      logic [7:0] prs;
      int         cyc;
   } exp_t;

   logic clk     = 1'b0;
   logic reset_n = 1'b1;
   logic rst_a_n = 1'b1;
   int   cyc     = 0;
   int   checks   = 0;
   int   failures = 0;
   exp_t q[$];
   logic [7:0] last_btn = 8'h00;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   nes_read_sequencer_if bus ();
   nes_read_sequencer_if bus_a ();

   nes_read_sequencer #(.CLK_DIV(4), .AUTO_POLL(0)) dut (
      .clk(clk), .reset_n(reset_n), .bus(bus)
   );
   nes_read_sequencer #(.CLK_DIV(4), .AUTO_POLL(1)) dut_a (
      .clk(clk), .reset_n(rst_a_n), .bus(bus_a)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Controller model: parallel load while latched, shift on pulse rise, active-low data.
   logic [7:0] pad_byte = 8'h00, pad_sr = 8'h00;
   logic [7:0] pad_a = 8'h11, pad_a_sr = 8'h00;
   logic       pq = 1'b0, pq_a = 1'b0;
   always @(posedge clk) begin
      if (bus.nes_latch) pad_sr <= pad_byte;
      else if (bus.nes_pulse && !pq) pad_sr <= {1'b0, pad_sr[7:1]};
      pq <= bus.nes_pulse;
      if (bus_a.nes_latch) pad_a_sr <= pad_a;
      else if (bus_a.nes_pulse && !pq_a) pad_a_sr <= {1'b0, pad_a_sr[7:1]};
      pq_a <= bus_a.nes_pulse;
   end
   assign bus.nes_data   = ~pad_sr[0];
   assign bus_a.nes_data = ~pad_a_sr[0];

   // Monitor for the start-driven instance.
   int   latch_len = 0, pulse_hi = 0, pulses = 0;
   logic prev_pulse = 1'b0;
   always @(negedge clk) begin
      if (!reset_n) begin
         latch_len = 0; pulse_hi = 0; pulses = 0; prev_pulse = 1'b0;
      end else begin
         if (bus.nes_latch) latch_len++;
         if (bus.nes_pulse) pulse_hi++;
         if (bus.nes_pulse && !prev_pulse) pulses++;
         prev_pulse = bus.nes_pulse;
         if (bus.valid) begin
            if (q.size() == 0) begin
               check("unexpected_valid", 32'd1, 32'd0);
            end else begin
               exp_t e;
               e = q.pop_front();
               check("buttons", 32'(bus.buttons), 32'(e.btn));
               check("valid_cycle", 32'(cyc), 32'(e.cyc));
               check("busy_in_done", 32'(bus.busy), 32'd0);
               check("latch_cycles", 32'(latch_len), 32'd8);
               check("pulse_count", 32'(pulses), 32'd8);
               check("pulse_high_cycles", 32'(pulse_hi), 32'd32);
`ifdef NES_PRESS_EDGE_EN
               check("pressed", 32'(bus.pressed), 32'(e.prs));
`endif
            end
            latch_len = 0; pulse_hi = 0; pulses = 0;
         end
      end
   end

   // Monitor for the AUTO_POLL instance: fixed period, buttons follow pad table.
   logic [7:0] auto_tab [4] = '{8'h11, 8'hE0, 8'h00, 8'hFF};
   int a_idx = 0, a_last = -1;
   always @(negedge clk) begin
      if (rst_a_n && bus_a.valid) begin
         if (a_last >= 0) check("auto_period", 32'(cyc - a_last), 32'd74);
         check("auto_buttons", 32'(bus_a.buttons), 32'(auto_tab[a_idx]));
         a_idx  = (a_idx + 1) % 4;
         pad_a  = auto_tab[a_idx];
         a_last = cyc;
      end
   end

   task automatic do_read(input logic [7:0] b);
      exp_t e;
      pad_byte  = b;
      bus.start = 1'b1;
      e.btn = b; e.prs = b & ~last_btn; e.cyc = cyc + 73;
      q.push_back(e);
      last_btn = b;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (80) @(posedge clk);
      #1;
      check("queue_drained", 32'(q.size()), 32'd0);
   endtask

   initial begin
      bus.start   = 1'b0;
      bus_a.start = 1'b0;
      #1 reset_n = 1'b0; rst_a_n = 1'b0;
      // Reset holds every output low regardless of inputs.
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         bus.start = i[0];
         pad_byte  = i[0] ? 8'hFF : 8'h00;
         check("rst_latch", 32'(bus.nes_latch), 32'd0);
         check("rst_pulse", 32'(bus.nes_pulse), 32'd0);
         check("rst_outs", {bus.buttons, 7'd0, bus.valid, 7'd0, bus.busy, 8'd0}, 32'd0);
      end
      bus.start = 1'b0;
      @(posedge clk); #1;
      reset_n = 1'b1; rst_a_n = 1'b1;
      repeat (2) @(posedge clk); #1;

      do_read(8'hA5);
      do_read(8'h00);
      do_read(8'hFF);

      // Start held high: back-to-back reads, start ignored while busy.
      begin
         int c0;
         exp_t e;
         c0 = cyc;
         pad_byte  = 8'h5A;
         bus.start = 1'b1;
         for (int k = 0; k < 3; k++) begin
            e.btn = 8'h5A; e.prs = (k == 0) ? (8'h5A & ~last_btn) : 8'h00;
            e.cyc = c0 + 73 + 74 * k;
            q.push_back(e);
         end
         last_btn = 8'h5A;
         repeat (200) @(posedge clk); #1;
         bus.start = 1'b0;
         repeat (40) @(posedge clk); #1;
         check("held_start_drained", 32'(q.size()), 32'd0);
      end

      // Mid-read reset aborts without a valid.
      pad_byte  = 8'h99;
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (29) @(posedge clk);
      #2 reset_n = 1'b0;
      #1;
      check("abort_pins", {30'd0, bus.nes_latch, bus.nes_pulse}, 32'd0);
      check("abort_busy", 32'(bus.busy), 32'd0);
      check("abort_buttons", 32'(bus.buttons), 32'd0);
      last_btn = 8'h00;
      repeat (3) @(posedge clk); #1;
      reset_n = 1'b1;
      repeat (2) @(posedge clk); #1;
      do_read(8'h3C);

      // Newly-pressed sequence; buttons checked in every build.
      do_read(8'h00);
      do_read(8'h81);
      do_read(8'h83);
      do_read(8'h02);

      check("auto_reads_seen", 32'(a_last > 0), 32'd1);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
